// File: rtl/seqdet_pkg.sv
// Shared definitions for the 01[0*]1 sequence detector slice: debounce FSM states,
// default debounce length and the press-count width reused by detector and display logic.
package seqdet_pkg;

    localparam int unsigned DebounceCyclesDefault = 500000;
    localparam int unsigned CountW                = 8;

    typedef enum logic [1:0] {
        StIdle,
        StPressChk,
        StHeld,
        StRelChk
    } deb_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, cleared by the async reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bit_entry_conditioner.sv
// Synchronises the data switch and step button, debounces the button and emits one
// registered strobe per accepted press with the sampled bit, a bit history and a press count.
module bit_entry_conditioner
    import seqdet_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault,
    parameter int unsigned HIST_W          = 8,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sw_raw,
    input  logic              btn_raw,
    output logic              bit_out,
    output logic              bit_valid,
    output logic [HIST_W-1:0] hist,
    output logic [CountW-1:0] press_count
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic btn_norm;
    logic sw_s;
    logic btn_s;

    // Normalise before synchronising so a cleared chain reads as "released".
    assign btn_norm = btn_raw ^ BTN_ACTIVE_LOW;

    sync2 u_sync_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sw_raw),
        .q     (sw_s)
    );

    sync2 u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_norm),
        .q     (btn_s)
    );

    deb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (btn_s) begin
                    state_d = StPressChk;
                    cnt_d   = '0;
                end
            end
            StPressChk: begin
                if (!btn_s) begin
                    state_d = StIdle;
                end else if (cnt_q == CntMax) begin
                    state_d = StHeld;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (!btn_s) begin
                    state_d = StRelChk;
                    cnt_d   = '0;
                end
            end
            StRelChk: begin
                if (btn_s) begin
                    state_d = StHeld;
                end else if (cnt_q == CntMax) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_out     <= 1'b0;
            bit_valid   <= 1'b0;
            hist        <= '0;
            press_count <= '0;
        end else begin
            bit_valid <= accept;
            if (accept) begin
                bit_out     <= sw_s;
                hist        <= {hist[HIST_W-2:0], sw_s};
                press_count <= press_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_entry_conditioner.sv
// Self-checking bench: directed scenarios plus random stimulus, every cycle compared
// against a run-length reference model of the debounced step button.
module tb_bit_entry_conditioner;

    localparam int unsigned D  = 4;
    localparam int unsigned HW = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          sw_raw  = 1'b0;
    logic          btn_raw = 1'b1;
    logic          bit_out;
    logic          bit_valid;
    logic [HW-1:0] hist;
    logic [7:0]    press_count;

    bit_entry_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .HIST_W          (HW),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_raw      (sw_raw),
        .btn_raw     (btn_raw),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .hist        (hist),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: raw inputs delayed two edges, press accepted after D+1
    // consecutive pressed samples while armed, re-armed after D+1 released samples.
    bit          m_sw1, m_sw2, m_bt1, m_bt2;
    bit          m_armed;
    int          m_ones, m_zeros;
    bit          m_bit, m_valid;
    bit [HW-1:0] m_hist;
    bit [7:0]    m_count;

    int edge_n;
    int n_strobe;
    int strobe_edge;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sw1   = 1'b0;
        m_sw2   = 1'b0;
        m_bt1   = 1'b0;
        m_bt2   = 1'b0;
        m_armed = 1'b1;
        m_ones  = 0;
        m_zeros = 0;
        m_bit   = 1'b0;
        m_valid = 1'b0;
        m_hist  = '0;
        m_count = '0;
    endtask

    task automatic model_tick();
        bit s_sw;
        bit s_bt;
        s_sw    = m_sw2;
        s_bt    = m_bt2;
        m_sw2   = m_sw1;
        m_sw1   = sw_raw;
        m_bt2   = m_bt1;
        m_bt1   = (btn_raw == 1'b0);
        m_valid = 1'b0;
        if (m_armed) begin
            if (s_bt) begin
                m_ones++;
                if (m_ones == D + 1) begin
                    m_valid = 1'b1;
                    m_bit   = s_sw;
                    m_hist  = {m_hist[HW-2:0], s_sw};
                    m_count = m_count + 8'd1;
                    m_armed = 1'b0;
                    m_zeros = 0;
                end
            end else begin
                m_ones = 0;
            end
        end else begin
            if (!s_bt) begin
                m_zeros++;
                if (m_zeros == D + 1) begin
                    m_armed = 1'b1;
                    m_ones  = 0;
                end
            end else begin
                m_zeros = 0;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("bit_valid", bit_valid, m_valid);
        check_eq("bit_out", bit_out, m_bit);
        check_eq("hist", hist, m_hist);
        check_eq("press_count", press_count, m_count);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_tick();
            #1;
            compare_all();
            edge_n++;
            if (bit_valid === 1'b1) begin
                n_strobe++;
                strobe_edge = edge_n;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic press(input bit sw, input int hold, input int rel);
        sw_raw  = sw;
        btn_raw = 1'b0;
        step(hold);
        btn_raw = 1'b1;
        step(rel);
    endtask

    initial begin
        bit [HW-1:0] exp_hist;
        bit          b;
        bit [4:0]    seq;

        #2;
        do_reset();
        step(3);

        // Clean press
        sw_raw      = 1'b1;
        btn_raw     = 1'b0;
        edge_n      = 0;
        n_strobe    = 0;
        strobe_edge = 0;
        step(20);
        btn_raw = 1'b1;
        step(20);
        check_eq("clean_strobes", n_strobe, 1);
        check_eq("clean_edge", strobe_edge, 7);
        check_eq("clean_bit", bit_out, 1);
        check_eq("clean_hist", hist, 8'h01);
        check_eq("clean_count", press_count, 1);

        // Bounce then stable press
        n_strobe = 0;
        for (int i = 0; i < 6; i++) begin
            btn_raw = ~btn_raw;
            step(2);
        end
        step(2);
        check_eq("bounce_none", n_strobe, 0);
        btn_raw = 1'b0;
        edge_n  = 0;
        step(12);
        check_eq("bounce_strobes", n_strobe, 1);
        check_eq("bounce_edge", strobe_edge, 7);
        btn_raw = 1'b1;
        step(20);

        // Sequence 0,1,0,0,1
        do_reset();
        step(3);
        n_strobe = 0;
        seq      = 5'b10010;
        for (int i = 0; i < 5; i++) press(seq[i], 10, 10);
        check_eq("seq_strobes", n_strobe, 5);
        check_eq("seq_hist", hist, 8'h09);
        check_eq("seq_count", press_count, 5);

        // Long hold with switch toggling
        n_strobe = 0;
        sw_raw   = 1'b0;
        btn_raw  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i % 3 == 0) sw_raw = ~sw_raw;
            step(1);
        end
        btn_raw = 1'b1;
        step(20);
        check_eq("hold_strobes", n_strobe, 1);
        check_eq("hold_count", press_count, 6);

        // 257 presses: count wraps to 1
        do_reset();
        step(3);
        exp_hist = '0;
        for (int i = 0; i < 257; i++) begin
            b        = 1'($urandom);
            exp_hist = {exp_hist[HW-2:0], b};
            press(b, 10, 10);
        end
        check_eq("wrap_count", press_count, 1);
        check_eq("wrap_hist", hist, exp_hist);

        // Reset mid-debounce with the button still held
        sw_raw  = 1'b1;
        btn_raw = 1'b0;
        step(5);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_count", press_count, 0);
        check_eq("midrst_hist", hist, 0);
        check_eq("midrst_valid", bit_valid, 0);
        step(2);
        rst_n    = 1'b1;
        edge_n   = 0;
        n_strobe = 0;
        step(12);
        check_eq("midrst_strobes", n_strobe, 1);
        check_eq("midrst_edge", strobe_edge, 7);
        btn_raw = 1'b1;
        step(20);

        // Random stimulus
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end else begin
                sw_raw  = 1'($urandom);
                btn_raw = 1'($urandom);
                step($urandom_range(1, 12));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bit_entry_conditioner.md
# bit_entry_conditioner

Front-end stage for the 01[0*]1 sequence detector on the lab board. It synchronises a raw slide switch (the data bit) and a raw push-button (the step key), and debounces the button. On each clean press it emits exactly one single-cycle strobe with the sampled bit. The downstream detector uses bit_valid as its enable and bit_out as its test signal. The block also keeps a shift history and a press count for board LEDs.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples needed to accept a press or release; legal range is 2 or more.
- HIST_W, 8: width of the bit-history shift register.
- BTN_ACTIVE_LOW, 1: 1 means the raw button reads 0 when pressed.
- clk  in  1  main clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- sw_raw  in  1  raw slide switch (data bit); asynchronous to clk.
- btn_raw  in  1  raw push-button; asynchronous to clk; bounces.
- bit_out  out  1  switch value captured at the last accepted press; held until the next one.
- bit_valid  out  1  one-cycle strobe per accepted press.
- hist  out  HIST_W  last HIST_W accepted bits; newest in bit 0.
- press_count  out  8  accepted presses, modulo 256.

## Operation
- Reset (rst_n=0, any time, asynchronous) forces the following:
  - bit_out=0, bit_valid=0, hist=0, press_count=0.
  - Debounce counter cleared; FSM in IDLE.
  - Both synchroniser chains cleared.
- Synchronisation:
  - sw_raw and btn_raw each pass through a 2-flop synchroniser, giving sw_s and btn_s.
  - btn_s is normalised so that 1 means pressed (inverted when BTN_ACTIVE_LOW=1).
- FSM states: IDLE, PRESS_CHK, HELD, REL_CHK. Counter cnt is wide enough for DEBOUNCE_CYCLES-1 and saturates there.
  - IDLE: if btn_s=1, go to PRESS_CHK with cnt=0. Otherwise stay.
  - PRESS_CHK: if btn_s=0, go to IDLE (bounce rejected). Else if cnt=DEBOUNCE_CYCLES-1, go to HELD and accept the press. Else cnt+1.
  - HELD: if btn_s=0, go to REL_CHK with cnt=0. Otherwise stay; holding the button never produces a second strobe.
  - REL_CHK: if btn_s=1, go back to HELD with no new strobe. Else if cnt=DEBOUNCE_CYCLES-1, go to IDLE. Else cnt+1.
- Accepting a press is a registered action on the edge that enters HELD:
  - bit_valid goes to 1 for exactly that one cycle.
  - bit_out takes sw_s.
  - hist becomes {hist[HIST_W-2:0], sw_s}.
  - press_count increments, wrapping 255 to 0.
- In all other cycles bit_valid=0 and bit_out, hist and press_count hold their values.
- sw_raw changes while the button is held have no effect until the next accepted press.

## Timing
- Press latency: with btn_raw stable-pressed from before edge 1, bit_valid is high after edge DEBOUNCE_CYCLES+3. That is 2 edges for synchronisation, 1 edge to enter PRESS_CHK, and DEBOUNCE_CYCLES edges of counting.
- Minimum spacing between strobes is about 2·DEBOUNCE_CYCLES+6 cycles, because a full release must be accepted between presses.
- bit_out and hist are valid in the same cycle as bit_valid, so the consumer samples both on its enable.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-debounce aborts immediately. After release, a still-held button is treated as a fresh press: it passes through IDLE and PRESS_CHK and yields one strobe.

## Structure
- Shared package seqdet_pkg holds:
  - the FSM state typedef (IDLE, PRESS_CHK, HELD, REL_CHK);
  - the DEBOUNCE_CYCLES default constant;
  - the 8-bit count width constant.
  
  The detector and display logic reuse the count width.
- One sub-module, sync2: a 2-flop synchroniser with async active-low clear, instantiated twice.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4, sw_raw=1, btn held 20 cycles, then released -> exactly one bit_valid pulse after edge 7; bit_out=1, hist=8'h01, press_count=1.
- Bounce: btn toggles every 2 cycles for 12 cycles, then is stable-pressed, DEBOUNCE_CYCLES=4 -> no strobe during bouncing; exactly one strobe 7 edges into the stable period.
- Sequence: presses with sw=0,1,0,0,1 -> five strobes; bit_out matches sw_raw at each strobe; final hist=8'h09, press_count=5.
- Hold: button held 100 cycles with sw toggling during the hold -> one strobe; bit_out equals sw at acceptance and is unchanged afterwards.
- Wrap: 257 clean presses -> press_count=1; hist equals the last 8 bits.
- Reset mid-operation: assert rst_n=0 at cnt=2 in PRESS_CHK, button still held -> all outputs 0 at once; after release, one strobe 7 edges later.
